// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// data-memory wait handling with a sticky timeout and statistics counters.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_LIM = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_ex,
  input  logic [4:0]  rd_ex,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        use_rs2_id,
  input  logic        branch_taken_ex,
  input  logic        dmem_req_mem,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_flush,
  output logic        exmem_write,
  output logic        memwb_write,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_MWAIT = 2'd1;
  localparam logic [1:0] S_TOUT  = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_use;
  logic              run_en;

  assign load_use = memread_ex && (rd_ex != 5'd0) &&
                    ((rd_ex == rs1_id) || (use_rs2_id && (rd_ex == rs2_id)));

  // Next state and zero-latency enable/flush decode
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    run_en       = 1'b0;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_write   = 1'b0;
    idex_flush   = 1'b0;
    exmem_write  = 1'b0;
    memwb_write  = 1'b0;

    case (state)
      S_RUN: begin
        if (dmem_req_mem && !dmem_ready) begin
          state_nxt    = S_MWAIT;
          wait_cnt_nxt = '0;
        end else begin
          run_en = 1'b1;
        end
      end
      S_MWAIT: begin
        if (dmem_ready) begin
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
          run_en       = 1'b1;
        end else if (wait_cnt == WAIT_W'(TIMEOUT_LIM)) begin
          state_nxt = S_TOUT;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_TOUT: begin
        state_nxt = S_TOUT;
      end
      default: begin
        state_nxt    = S_RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    // Branch flush wins over the load-use bubble
    if (run_en) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
      if (branch_taken_ex) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end

    if (reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_flush  = 1'b0;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
    end
  end

  // State, wait counter, sticky timeout and saturating statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == S_TOUT) begin
        mem_timeout <= 1'b1;
      end
      if (!pc_write && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (ifid_flush && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT_LIM=4.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread_ex;
  logic [4:0]  rd_ex, rs1_id, rs2_id;
  logic        use_rs2_id, branch_taken_ex, dmem_req_mem, dmem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic        exmem_write, memwb_write, mem_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  int errors = 0;
  int checks = 0;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_write}
  localparam logic [6:0] EN_NORM  = 7'b1101011;
  localparam logic [6:0] EN_LU    = 7'b0001111;
  localparam logic [6:0] EN_BR    = 7'b1111111;
  localparam logic [6:0] EN_STALL = 7'b0000000;

  pipe_hazard_ctrl #(.TIMEOUT_LIM(4)) dut (
    .clk(clk), .reset(reset), .memread_ex(memread_ex), .rd_ex(rd_ex),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs2_id(use_rs2_id),
    .branch_taken_ex(branch_taken_ex), .dmem_req_mem(dmem_req_mem),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  wire [6:0] en = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                   exmem_write, memwb_write};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    memread_ex = 1'b0; rd_ex = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0;
    use_rs2_id = 1'b0; branch_taken_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b0;
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    settle();
    check("reset_en", 32'(en), 32'(EN_NORM));
    tick();
    check("reset_stall", stall_cycles, 32'd0);
    check("reset_flush", 32'(flush_count), 32'd0);
    check("reset_tout", 32'(mem_timeout), 32'd0);
    reset = 1'b0;
    settle();
    check("idle_en", 32'(en), 32'(EN_NORM));
    tick();

    // Load-use on rs1: one-cycle bubble
    memread_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
    settle();
    check("lu_en", 32'(en), 32'(EN_LU));
    tick();
    check("lu_stall", stall_cycles, 32'd1);
    clear_inputs();
    settle();
    check("lu_after_en", 32'(en), 32'(EN_NORM));
    tick();

    // x0 and rs2 gating
    memread_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
    settle();
    check("x0_en", 32'(en), 32'(EN_NORM));
    rd_ex = 5'd7; rs1_id = 5'd3; rs2_id = 5'd7; use_rs2_id = 1'b0;
    settle();
    check("rs2_unused_en", 32'(en), 32'(EN_NORM));
    use_rs2_id = 1'b1;
    settle();
    check("rs2_used_en", 32'(en), 32'(EN_LU));
    tick();
    check("rs2_stall", stall_cycles, 32'd2);

    // Branch overrides load-use
    clear_inputs();
    memread_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; branch_taken_ex = 1'b1;
    settle();
    check("br_lu_en", 32'(en), 32'(EN_BR));
    tick();
    check("br_flush", 32'(flush_count), 32'd1);
    check("br_stall", stall_cycles, 32'd2);

    // Memory wait: 3 not-ready cycles then release
    clear_inputs();
    dmem_req_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("mwait_en%0d", i), 32'(en), 32'(EN_STALL));
      tick();
    end
    check("mwait_stall3", stall_cycles, 32'd5);
    dmem_ready = 1'b1;
    settle();
    check("release_en", 32'(en), 32'(EN_NORM));
    tick();
    check("release_stall", stall_cycles, 32'd5);

    // Release cycle with a load-use still applies the bubble
    dmem_ready = 1'b0;
    tick();
    memread_ex = 1'b1; rd_ex = 5'd9; rs1_id = 5'd9; dmem_ready = 1'b1;
    settle();
    check("release_lu_en", 32'(en), 32'(EN_LU));
    tick();
    check("release_lu_stall", stall_cycles, 32'd7);

    // Timeout: RUN cycle + 5 MWAIT cycles, then TOUT
    clear_inputs();
    dmem_req_mem = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("tout_not_yet", 32'(mem_timeout), 32'd0);
    tick();
    check("tout_set", 32'(mem_timeout), 32'd1);
    check("tout_stall", stall_cycles, 32'd13);
    dmem_ready = 1'b1;
    settle();
    check("tout_ready_en", 32'(en), 32'(EN_STALL));
    tick();
    check("tout_sticky", 32'(mem_timeout), 32'd1);
    check("tout_stall_inc", stall_cycles, 32'd14);

    // Reset recovery from TOUT
    reset = 1'b1;
    settle();
    check("tout_reset_en", 32'(en), 32'(EN_NORM));
    tick();
    reset = 1'b0;
    clear_inputs();
    settle();
    check("rec_tout", 32'(mem_timeout), 32'd0);
    check("rec_stall", stall_cycles, 32'd0);
    check("rec_flush", 32'(flush_count), 32'd0);
    check("rec_en", 32'(en), 32'(EN_NORM));
    dmem_req_mem = 1'b1; dmem_ready = 1'b1;
    settle();
    check("rec_ready_en", 32'(en), 32'(EN_NORM));
    tick();
    check("rec_stall_hold", stall_cycles, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
